// File: rtl/encoder_if.sv
// Bit-in / symbol-out bus of the rate-1/2 convolutional encoder.
// The master drives information bits and the slave returns registered code symbols.
interface encoder_if;
    logic       in;
    logic [1:0] out;

    modport master (output in, input  out);
    modport slave  (input  in, output out);
endinterface

// File: rtl/encoder.sv
// Rate-1/2 convolutional encoder with generators G0 -> out[1] and G1 -> out[0].
// Bit K-1 of each generator taps the current input, and bit 0 taps the oldest memory bit.
module encoder #(
    parameter int unsigned K  = 3,
    parameter logic [31:0] G0 = 32'o7,
    parameter logic [31:0] G1 = 32'o5
) (
    input  logic      clk,
    input  logic      reset,
    encoder_if.slave  bus
);

    localparam int unsigned SW = K - 1;
    localparam logic [K-1:0] G0_TAPS = G0[K-1:0];
    localparam logic [K-1:0] G1_TAPS = G1[K-1:0];

    logic [SW-1:0] s_q, s_d;
    logic [1:0]    out_q, out_d;
    logic [K-1:0]  tap_v;

    // Parity of the tapped window; shift the new bit in from the top toward s[0].
    always_comb begin
        tap_v = {bus.in, s_q};
        out_d = {^(tap_v & G0_TAPS), ^(tap_v & G1_TAPS)};
        s_d   = SW'(tap_v >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q   <= '0;
            out_q <= 2'b00;
        end else begin
            s_q   <= s_d;
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_encoder.sv
// Randomised and directed scoreboard bench for the encoder, covering K=3 (7,5) and K=7 (171,133).
// The reference model is the convolution of the input history with each generator.
module tb_encoder;

    localparam logic [31:0] G0_3 = 32'o7;
    localparam logic [31:0] G1_3 = 32'o5;
    localparam logic [31:0] G0_7 = 32'o171;
    localparam logic [31:0] G1_7 = 32'o133;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    encoder_if b3();
    encoder_if b7();

    encoder #(.K(3), .G0(G0_3), .G1(G1_3)) u_enc3 (.clk(clk), .reset(reset), .bus(b3));
    encoder #(.K(7), .G0(G0_7), .G1(G1_7)) u_enc7 (.clk(clk), .reset(reset), .bus(b7));

    int checks = 0;
    int errors = 0;

    logic [1:0] q3[$];
    logic [1:0] q7[$];
    bit         h3[$];
    bit         h7[$];

    // y[n] = XOR_j g[K-1-j] & x[n-j], where history before the last reset is zero.
    function automatic logic [1:0] model(input int unsigned k, input logic [31:0] g0,
                                         input logic [31:0] g1, input bit h[$]);
        logic p1, p0, x;
        p1 = 1'b0;
        p0 = 1'b0;
        for (int j = 0; j < int'(k); j++) begin
            x  = (j < h.size()) ? h[h.size() - 1 - j] : 1'b0;
            p1 = p1 ^ (g0[k - 1 - j] & x);
            p0 = p0 ^ (g1[k - 1 - j] & x);
        end
        return {p1, p0};
    endfunction

    // Apply one edge. The K=3 expectation is the given constant when use_e is set,
    // and otherwise comes from the model.
    task automatic step(input bit r, input bit b, input bit use_e, input logic [1:0] e3);
        reset = r;
        b3.in = b;
        b7.in = b;
        @(posedge clk);
        if (r) begin
            h3.delete();
            h7.delete();
            q3.push_back(2'b00);
            q7.push_back(2'b00);
        end else begin
            h3.push_back(b);
            h7.push_back(b);
            q3.push_back(use_e ? e3 : model(3, G0_3, G1_3, h3));
            q7.push_back(model(7, G0_7, G1_7, h7));
        end
        #1;
    endtask

    // Every cycle carries a symbol, so compare one entry per falling edge.
    always @(negedge clk) begin
        logic [1:0] e;
        if (q3.size() > 0) begin
            e = q3.pop_front();
            checks++;
            if (b3.out !== e) begin
                errors++;
                $display("FAIL k3_sym check %0d: got %b expected %b", checks, b3.out, e);
            end
        end
        if (q7.size() > 0) begin
            e = q7.pop_front();
            checks++;
            if (b7.out !== e) begin
                errors++;
                $display("FAIL k7_sym check %0d: got %b expected %b", checks, b7.out, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        b3.in = 1'b0;
        b7.in = 1'b0;
        @(negedge clk);

        // Hold zero after reset, then apply an impulse.
        step(1'b1, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, 1'b1, 2'b10);
        step(1'b0, 1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b0, 1'b1, 2'b00);

        // Pattern 1,0,1,1
        step(1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, 1'b1, 2'b10);
        step(1'b0, 1'b1, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b01);

        // All ones
        step(1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 2'b10);

        // Mid-stream reset with in=1 on the reset edge (it must be ignored)
        step(1'b1, 1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, 1'b1, 2'b10);

        // Long random stream with occasional resets
        step(1'b1, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 249) == 0), 1'($urandom), 1'b0, 2'b00);
        end
        step(1'b0, 1'b0, 1'b0, 2'b00);

        repeat (3) @(negedge clk);
        if (q3.size() != 0 || q7.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d symbols left unchecked, expected 0", q3.size(), q7.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
